pe_link_tx: RTL and testbench

//  Transmit end of the PE-to-PE data link in the RISC-V CGRA fabric. The PE datapath

---
 rtl/pe_link_pkg.sv | 10 +
 rtl/pe_link_tx_if.sv | 18 +
 rtl/pe_link_fifo_mem.sv | 29 ++
 rtl/pe_link_tx.sv | 81 ++++++++
 tb/tb_pe_link_tx.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/pe_link_pkg.sv
// Shared definitions for the PE-to-PE data link (transmit and receive ends).
package pe_link_pkg;

    // Default link word width used across the CGRA mesh.
    localparam int LINK_DATA_W = 32;

    // One word as carried on the link.
    typedef logic [LINK_DATA_W-1:0] link_word_t;

endpackage : pe_link_pkg

// File: rtl/pe_link_tx_if.sv
// Valid/ready link from a PE transmit FIFO toward the neighbour PE receive register.
interface pe_link_tx_if
    import pe_link_pkg::*;
#(
    parameter int DATA_W = LINK_DATA_W
);

    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    // Sending side: drives valid/data, observes ready.
    modport master (output tx_valid, output tx_data, input tx_ready);

    // Receiving side: observes valid/data, drives ready.
    modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface : pe_link_tx_if

// File: rtl/pe_link_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module pe_link_fifo_mem
    import pe_link_pkg::*;
#(
    parameter int DATA_W = LINK_DATA_W,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write the addressed entry on a push.
    // NOTE: storage has no reset; occupancy tracking guarantees no stale entry is ever presented.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : pe_link_fifo_mem

// File: rtl/pe_link_tx.sv
// Transmit end of the PE-to-PE link: buffers PE writeback words in a small FIFO and
// drains them in order over a valid/ready link.
module pe_link_tx
    import pe_link_pkg::*;
#(
    parameter int DATA_W = LINK_DATA_W,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w_enable,
    input  logic [DATA_W-1:0] data_in,
    input  logic              flush,
    pe_link_tx_if.master      link,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] head;
    logic              push;
    logic              pop;
    logic              mem_we;

    // Flags come from the registered count only, so tx_ready never reaches tx_valid.
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A pop needs a presented word; a push into a full FIFO is allowed when a pop frees a slot.
    assign pop    = !empty && link.tx_ready;
    assign push   = w_enable && (!full || pop);
    assign mem_we = push && !flush && !reset;

    pe_link_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointer, occupancy and sticky overflow update; reset and flush win over traffic.
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (w_enable && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head word is presented whenever the FIFO holds data; zero when idle.
    assign link.tx_valid = !empty;
    assign link.tx_data  = empty ? '0 : head;

endmodule : pe_link_tx

// File: tb/tb_pe_link_tx.sv
// Directed bench for pe_link_tx with a queue scoreboard of words expected on the link.
module tb_pe_link_tx;
    import pe_link_pkg::*;

    localparam int DATA_W = LINK_DATA_W;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              w_enable;
    logic [DATA_W-1:0] data_in;
    logic              flush;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    pe_link_tx_if #(.DATA_W(DATA_W)) link ();

    pe_link_tx #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .w_enable (w_enable),
        .data_in  (data_in),
        .flush    (flush),
        .link     (link),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    int                n_compared   = 0;
    int                n_mismatched = 0;
    logic [DATA_W-1:0] sb_q [$];
    logic              exp_ovf    = 1'b0;
    logic              hold_valid = 1'b0;
    logic [DATA_W-1:0] hold_data  = '0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check outputs at the negedge against the model, then advance the model across the next posedge.
    task automatic cycle();
        logic m_pop;
        logic m_push;
        @(negedge clock);
        check("tx_valid", DATA_W'(link.tx_valid), DATA_W'(sb_q.size() != 0));
        check("count",    DATA_W'(count),         DATA_W'(sb_q.size()));
        check("full",     DATA_W'(full),          DATA_W'(sb_q.size() == DEPTH));
        check("empty",    DATA_W'(empty),         DATA_W'(sb_q.size() == 0));
        check("overflow", DATA_W'(overflow),      DATA_W'(exp_ovf));
        if (sb_q.size() != 0) check("tx_data", link.tx_data, sb_q[0]);
        if (hold_valid)       check("tx_data_stable", link.tx_data, hold_data);

        m_pop  = (sb_q.size() != 0) && link.tx_ready;
        m_push = w_enable && ((sb_q.size() < DEPTH) || m_pop);
        hold_valid = link.tx_valid && !link.tx_ready && !flush && !reset;
        hold_data  = link.tx_data;
        if (reset || flush) begin
            sb_q.delete();
            exp_ovf = 1'b0;
        end else begin
            if (m_pop)  void'(sb_q.pop_front());
            if (m_push) sb_q.push_back(data_in);
            if (w_enable && !m_push) exp_ovf = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        w_enable = 1'b1;
        data_in  = d;
        cycle();
        w_enable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; w_enable = 1'b0; data_in = '0; flush = 1'b0; link.tx_ready = 1'b0;

        // Reset state.
        cycle();
        cycle();
        check("reset_tx_data", link.tx_data, '0);
        reset = 1'b0;

        // Single word with the neighbour ready: visible one cycle later, then consumed.
        link.tx_ready = 1'b1;
        push_word(32'hDEAD_BEEF);
        check("single_valid", DATA_W'(link.tx_valid), DATA_W'(1));
        cycle();
        cycle();
        check("single_empty", DATA_W'(empty), DATA_W'(1));

        // Fill under back-pressure, overflow on the fifth push, drain only the first four.
        link.tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_word(DATA_W'(i));
        cycle();
        check("fill_count", DATA_W'(count), DATA_W'(4));
        push_word(32'h5);
        cycle();
        check("ovf_set", DATA_W'(overflow), DATA_W'(1));
        link.tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        check("drain_empty", DATA_W'(empty), DATA_W'(1));
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        check("ovf_cleared", DATA_W'(overflow), DATA_W'(0));

        // Alternating back-pressure while pushing eight words.
        for (int i = 0; i < 8; i++) begin
            link.tx_ready = i[0];
            push_word(32'h100 + DATA_W'(i));
        end
        for (int i = 0; i < 14; i++) begin
            link.tx_ready = i[0];
            cycle();
        end
        link.tx_ready = 1'b1;
        cycle();
        cycle();

        // Full with simultaneous push and pop across pointer wrap.
        link.tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h200 + DATA_W'(i));
        link.tx_ready = 1'b1;
        for (int i = 4; i < 12; i++) begin
            push_word(32'h200 + DATA_W'(i));
            check("full_pp_count", DATA_W'(count), DATA_W'(4));
            check("full_pp_ovf", DATA_W'(overflow), DATA_W'(0));
        end
        for (int i = 0; i < 6; i++) cycle();

        // Flush with three words buffered and a push in the same cycle.
        link.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(32'h300 + DATA_W'(i));
        flush = 1'b1;
        push_word(32'h0BAD);
        flush = 1'b0;
        check("flush_count", DATA_W'(count), DATA_W'(0));
        check("flush_valid", DATA_W'(link.tx_valid), DATA_W'(0));
        link.tx_ready = 1'b1;
        cycle();
        cycle();

        // Reset mid-stream, then normal delivery resumes.
        link.tx_ready = 1'b0;
        push_word(32'h400);
        push_word(32'h401);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_mid_valid", DATA_W'(link.tx_valid), DATA_W'(0));
        check("rst_mid_count", DATA_W'(count), DATA_W'(0));
        link.tx_ready = 1'b1;
        push_word(32'h777);
        check("post_rst_data", link.tx_data, 32'h777);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_pe_link_tx
